// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte in, framed serial bits out.
// Define UART_TX_PARITY_EN to add a parity bit between data and stop bits.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            ready_o <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        state   <= START;
                        cnt     <= '0;
                        idx     <= '0;
                        shreg   <= data_i;
                        tx_o    <= 1'b0;
                        busy_o  <= 1'b1;
                        ready_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^data_i) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        cnt   <= '0;
                        idx   <= '0;
                        tx_o  <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == DATA_LAST) begin
                            idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= par_q;
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            shreg <= shreg >> 1;
                            tx_o  <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        cnt   <= '0;
                        idx   <= '0;
                        tx_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == STOP_LAST) begin
                            state   <= IDLE;
                            idx     <= '0;
                            done_o  <= 1'b0;
                            busy_o  <= 1'b0;
                            ready_o <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // registered pulse must land on the last cycle
                        if (idx == STOP_LAST && cnt == CNT_PENULT)
                            done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
